keypad_scan_onehot: RTL and testbench
=====================================

// Module: keypad_scan_onehot
// PURPOSE
//  4x4 matrix-keypad scanner: drives rows, samples columns, debounces, and emits the 16-bit one-hot key
//  code consumed by the keypad decoder/password logic (onehot input, level-held while pressed).
//  Sits between the board keypad pins and the decoder; all timing derived from the 50 MHz system clock.
// PARAMETERS
//  SCAN_DIV         50_000  clk cycles each row is driven (1 ms @ 50 MHz); min 4
//  DEBOUNCE_FRAMES  20      consecutive identical full-matrix frames required before onehot updates; min 2
// PORTS
//  clk       in   1   system clock, 50 MHz
//  RSTn      in   1   synchronous reset, active-high (port name per codebase; asserted = 1)
//  col_n     in   4   keypad columns, active-low (pulled up; 0 = key closed on driven row), asynchronous
//  row_n     out  4   keypad row drive, active-low, exactly one bit low at all times
//  onehot    out  16  debounced key code; bit (4*row+col) = 1 while that single key held, else 16'h0000
//  key_pulse out  1   1-cycle strobe when onehot changes to a new non-zero value
//  multi_key out  1   level: debounced frame has >=2 keys closed (onehot forced to 0)
// BEHAVIOUR
//  Reset (RSTn=1 at clk edge): row_n=4'b1110, onehot=0, key_pulse=0, multi_key=0, all counters/frames=0,
//   synchroniser flops=4'b1111. Reset mid-scan aborts the frame; no partial frame is ever used.
//  col_n passes a 2-flop synchroniser before any use.
//  Row FSM: ROW0->ROW1->ROW2->ROW3->ROW0, row_n = ~(1<<row); slot counter 0..SCAN_DIV-1, advance on wrap.
//  Sampling: in slot cycle SCAN_DIV-1 (settled), raw[4*row+c] <= ~col_sync[c] for c=0..3.
//  Frame end = sample cycle of ROW3. At frame end compare assembled frame to previous frame:
//   - equal: stable_cnt <= min(stable_cnt+1, DEBOUNCE_FRAMES-1); differ: stable_cnt <= 0.
//   - when stable_cnt reaches DEBOUNCE_FRAMES-1 the frame is "debounced"; outputs update the next cycle.
//  Output decode of debounced frame: popcount 0 -> onehot=0, multi_key=0; popcount 1 -> onehot=frame;
//   popcount >=2 -> onehot=0, multi_key=1 (ghosting/chord rejected, decoder sees no key).
//  key_pulse=1 for exactly one cycle when onehot goes to a non-zero value different from its prior value;
//   never on release, never on repeat of same debounced frame (holding a key gives one pulse only).
//  Latency: stable press to onehot = up to (DEBOUNCE_FRAMES+1) frames (frame=4*SCAN_DIV clk) + 3 clk.
//  Release: same debounce rule; onehot returns to 0 after DEBOUNCE_FRAMES identical all-zero frames.
//  Bounce shorter than DEBOUNCE_FRAMES frames never reaches onehot. Counters never wrap beyond limits.
//  Key map (row,col)->bit fixed by board wiring: e.g. bit0=ENTER, bit8=CLEAR, bit12=CANCEL, bit3='0'.
// STRUCTURE
//  Shared include keypad_defs.vh: KEY_ENTER=16'h0001, KEY_0=16'h0008, KEY_3=16'h0020, KEY_2=16'h0040,
//   KEY_1=16'h0080, KEY_CLEAR=16'h0100, KEY_6=16'h0200, KEY_5=16'h0400, KEY_4=16'h0800,
//   KEY_CANCEL=16'h1000, KEY_9=16'h2000, KEY_8=16'h4000, KEY_7=16'h8000, KEY_NONE=16'h0000; also used by decoder.
//  One sub-module: keypad_frame_debounce (frame compare, stable_cnt, popcount decode, key_pulse);
//   scanner top holds synchroniser, row FSM, slot counter, frame assembly.
// TESTING  (bench params SCAN_DIV=4, DEBOUNCE_FRAMES=3; keypad model closes col when row_n of key is low)
//  1 Reset held 3 clk, release, no keys -> row_n cycles 1110,1101,1011,0111 every 4 clk; onehot=0, no pulse.
//  2 Hold key (row1,col2) steadily -> onehot=16'h0040 within 4 frames+3 clk; key_pulse exactly once;
//    release -> onehot=0 after 3 stable frames, no pulse.
//  3 Bounce key (row0,col0) toggling every frame for 10 frames then steady -> onehot stays 0 during bounce,
//    then 16'h0001 with one pulse.
//  4 Hold (row2,col0) and (row2,col1) together -> multi_key=1, onehot=0, no pulse; drop (row2,col1)
//    -> multi_key=0, onehot=16'h0100, one pulse.
//  5 Hold (row3,col3) until onehot=16'h8000, assert RSTn for 1 clk mid-frame -> next cycle onehot=0,
//    row_n=1110; key still held -> onehot=16'h8000 again after full debounce, one new pulse.
//  6 Slide directly from KEY_5 to KEY_4 (no release frame) -> onehot 16'h0400 -> 16'h0800, pulse on each.

Source files
------------

// File: rtl/keypad_scan_onehot_pkg.sv
// Shared types, key-code constants and helpers for the 4x4 keypad scanner and its debouncer.
// Key codes follow the board wiring: bit (4*row+col) is set for the key at (row, col).
package keypad_scan_onehot_pkg;

    typedef enum logic [1:0] {
        ROW0 = 2'd0,
        ROW1 = 2'd1,
        ROW2 = 2'd2,
        ROW3 = 2'd3
    } row_state_e;

    localparam logic [15:0] KEY_NONE   = 16'h0000;
    localparam logic [15:0] KEY_ENTER  = 16'h0001;
    localparam logic [15:0] KEY_0      = 16'h0008;
    localparam logic [15:0] KEY_3      = 16'h0020;
    localparam logic [15:0] KEY_2      = 16'h0040;
    localparam logic [15:0] KEY_1      = 16'h0080;
    localparam logic [15:0] KEY_CLEAR  = 16'h0100;
    localparam logic [15:0] KEY_6      = 16'h0200;
    localparam logic [15:0] KEY_5      = 16'h0400;
    localparam logic [15:0] KEY_4      = 16'h0800;
    localparam logic [15:0] KEY_CANCEL = 16'h1000;
    localparam logic [15:0] KEY_9      = 16'h2000;
    localparam logic [15:0] KEY_8      = 16'h4000;
    localparam logic [15:0] KEY_7      = 16'h8000;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

    // Active-low row drive: exactly one row pulled low.
    function automatic logic [3:0] row_drive(input row_state_e r);
        return ~(4'b0001 << r);
    endfunction

endpackage

// File: rtl/keypad_frame_debounce.sv
// Whole-frame debouncer: counts identical consecutive frames, then decodes the stable frame
// into a one-hot key code (chords rejected as multi_key) and strobes key_pulse on a new key.
module keypad_frame_debounce
    import keypad_scan_onehot_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 20
) (
    input  logic        clk,
    input  logic        RSTn,
    input  logic        frame_valid_i,
    input  logic [15:0] frame_i,
    output logic [15:0] onehot_o,
    output logic        key_pulse_o,
    output logic        multi_key_o
);

    localparam int CNT_W = (DEBOUNCE_FRAMES > 2) ? $clog2(DEBOUNCE_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_FRAMES - 1);

    logic [15:0]      prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      onehot_q, onehot_d;
    logic             multi_q, multi_d;
    logic             pulse_q, pulse_d;
    logic [4:0]       pc;

    always_ff @(posedge clk) begin
        if (RSTn) begin
            prev_q   <= '0;
            cnt_q    <= '0;
            onehot_q <= '0;
            multi_q  <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            onehot_q <= onehot_d;
            multi_q  <= multi_d;
            pulse_q  <= pulse_d;
        end
    end

    always_comb begin
        prev_d   = prev_q;
        cnt_d    = cnt_q;
        onehot_d = onehot_q;
        multi_d  = multi_q;
        pc       = popcount16(prev_q);

        if (frame_valid_i) begin
            prev_d = frame_i;
            if (frame_i == prev_q) begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end

        // Decode only once the stored frame has survived the full debounce window.
        if (cnt_q == CNT_MAX) begin
            if (pc == 5'd0) begin
                onehot_d = KEY_NONE;
                multi_d  = 1'b0;
            end else if (pc == 5'd1) begin
                onehot_d = prev_q;
                multi_d  = 1'b0;
            end else begin
                onehot_d = KEY_NONE;
                multi_d  = 1'b1;
            end
        end

        pulse_d = (onehot_d != KEY_NONE) && (onehot_d != onehot_q);
    end

    assign onehot_o    = onehot_q;
    assign key_pulse_o = pulse_q;
    assign multi_key_o = multi_q;

endmodule

// File: rtl/keypad_scan_onehot.sv
// 4x4 matrix keypad scanner: synchronises columns, walks the active-low row drive and
// assembles one full-matrix frame per scan before handing it to the frame debouncer.
module keypad_scan_onehot
    import keypad_scan_onehot_pkg::*;
#(
    parameter int SCAN_DIV        = 50_000,
    parameter int DEBOUNCE_FRAMES = 20
) (
    input  logic        clk,
    input  logic        RSTn,
    input  logic [3:0]  col_n,
    output logic [3:0]  row_n,
    output logic [15:0] onehot,
    output logic        key_pulse,
    output logic        multi_key
);

    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);

    logic [3:0]        sync1_q, sync2_q;
    row_state_e        row_q, row_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [11:0]       raw_q, raw_d;
    logic              frame_valid;
    logic [15:0]       frame;

    always_ff @(posedge clk) begin
        if (RSTn) begin
            sync1_q <= 4'b1111;
            sync2_q <= 4'b1111;
            row_q   <= ROW0;
            slot_q  <= '0;
            raw_q   <= '0;
        end else begin
            sync1_q <= col_n;
            sync2_q <= sync1_q;
            row_q   <= row_d;
            slot_q  <= slot_d;
            raw_q   <= raw_d;
        end
    end

    // Columns are sampled only in the last slot cycle so the synchroniser has settled on the
    // current row; row 3 is never stored, it completes the frame directly.
    always_comb begin
        slot_d      = slot_q + SLOT_W'(1);
        row_d       = row_q;
        raw_d       = raw_q;
        frame_valid = 1'b0;
        frame       = {~sync2_q, raw_q};

        if (slot_q == SLOT_LAST) begin
            slot_d = '0;
            row_d  = row_state_e'(row_q + 2'd1);
            case (row_q)
                ROW0:    raw_d[3:0]  = ~sync2_q;
                ROW1:    raw_d[7:4]  = ~sync2_q;
                ROW2:    raw_d[11:8] = ~sync2_q;
                default: frame_valid = 1'b1;
            endcase
        end
    end

    assign row_n = row_drive(row_q);

    keypad_frame_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk          (clk),
        .RSTn         (RSTn),
        .frame_valid_i(frame_valid),
        .frame_i      (frame),
        .onehot_o     (onehot),
        .key_pulse_o  (key_pulse),
        .multi_key_o  (multi_key)
    );

endmodule

// File: tb/tb_keypad_scan_onehot.sv
// Self-checking bench for keypad_scan_onehot with a behavioural keypad matrix model and a
// pulse scoreboard: each expected key code is queued when stimulus is applied, popped on key_pulse.
module tb_keypad_scan_onehot;
    import keypad_scan_onehot_pkg::*;

    localparam int SD    = 4;
    localparam int DF    = 3;
    localparam int FRAME = 4 * SD;
    localparam int LIMIT = 4 * FRAME + 3;

    logic        clk = 1'b0;
    logic        RSTn;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [15:0] onehot;
    logic        key_pulse;
    logic        multi_key;

    logic [15:0] keys;
    logic [15:0] expQ[$];
    logic [15:0] expVal;
    int          vectors = 0;
    int          miscompares = 0;
    int          pulseCount = 0;

    keypad_scan_onehot #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_FRAMES(DF)
    ) dut (
        .clk      (clk),
        .RSTn     (RSTn),
        .col_n    (col_n),
        .row_n    (row_n),
        .onehot   (onehot),
        .key_pulse(key_pulse),
        .multi_key(multi_key)
    );

    always #5 clk = ~clk;

    // A held key pulls its column low whenever its row is driven low.
    always_comb begin
        col_n = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            if (!row_n[r]) begin
                for (int c = 0; c < 4; c++) begin
                    if (keys[4*r+c]) col_n[c] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (key_pulse === 1'b1) begin
            pulseCount++;
            vectors++;
            if (expQ.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL pulse_unexpected: onehot=%h, no pulse was expected", onehot);
            end else begin
                expVal = expQ.pop_front();
                if (onehot !== expVal) begin
                    miscompares++;
                    $display("[TB] FAIL pulse_value: onehot=%h, expected %h", onehot, expVal);
                end
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [3:0] expRow;
        RSTn = 1'b1;
        keys = KEY_NONE;
        waitCycles(3);
        vectors++;
        if (row_n !== 4'b1110) begin
            miscompares++;
            $display("[TB] FAIL reset_row: row_n=%b expected 1110", row_n);
        end
        vectors++;
        if (onehot !== KEY_NONE || key_pulse !== 1'b0 || multi_key !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: onehot=%h pulse=%b multi=%b expected 0000/0/0",
                     onehot, key_pulse, multi_key);
        end
        RSTn = 1'b0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            expRow = 4'b1111 ^ (4'b0001 << ((k / SD) % 4));
            vectors++;
            if (row_n !== expRow) begin
                miscompares++;
                $display("[TB] FAIL row_scan: cycle %0d row_n=%b expected %b", k, row_n, expRow);
            end
            @(negedge clk);
        end
        waitCycles(2 * FRAME);
        vectors++;
        if (onehot !== KEY_NONE || pulseCount != 0) begin
            miscompares++;
            $display("[TB] FAIL idle_outputs: onehot=%h pulses=%0d expected 0000/0", onehot, pulseCount);
        end
    endtask

    task automatic test_hold();
        int n;
        int p0;
        p0 = pulseCount;
        expQ.push_back(KEY_2);
        keys = KEY_2;
        n = 0;
        while (onehot !== KEY_2 && n < LIMIT) begin @(negedge clk); n++; end
        vectors++;
        if (onehot !== KEY_2) begin
            miscompares++;
            $display("[TB] FAIL hold_press: onehot=%h expected %h after %0d clk", onehot, KEY_2, n);
        end
        waitCycles(3 * FRAME);
        vectors++;
        if (onehot !== KEY_2 || pulseCount - p0 != 1) begin
            miscompares++;
            $display("[TB] FAIL hold_steady: onehot=%h pulses=%0d expected %h/1", onehot, pulseCount - p0, KEY_2);
        end
        p0 = pulseCount;
        keys = KEY_NONE;
        waitCycles(24);
        vectors++;
        if (onehot !== KEY_2) begin
            miscompares++;
            $display("[TB] FAIL release_early: onehot=%h expected %h still held", onehot, KEY_2);
        end
        n = 0;
        while (onehot !== KEY_NONE && n < LIMIT) begin @(negedge clk); n++; end
        waitCycles(3 * FRAME);
        vectors++;
        if (onehot !== KEY_NONE || pulseCount != p0) begin
            miscompares++;
            $display("[TB] FAIL hold_release: onehot=%h pulses=%0d expected 0000/0", onehot, pulseCount - p0);
        end
    endtask

    task automatic test_bounce();
        int n;
        int p0;
        logic sawKey;
        p0 = pulseCount;
        sawKey = 1'b0;
        for (int i = 0; i < 10; i++) begin
            keys = (i % 2 == 0) ? KEY_ENTER : KEY_NONE;
            for (int j = 0; j < FRAME; j++) begin
                @(negedge clk);
                if (onehot !== KEY_NONE) sawKey = 1'b1;
            end
        end
        vectors++;
        if (sawKey || pulseCount != p0) begin
            miscompares++;
            $display("[TB] FAIL bounce_leak: onehot seen=%b pulses=%0d expected 0/0", sawKey, pulseCount - p0);
        end
        expQ.push_back(KEY_ENTER);
        keys = KEY_ENTER;
        n = 0;
        while (onehot !== KEY_ENTER && n < LIMIT) begin @(negedge clk); n++; end
        waitCycles(2 * FRAME);
        vectors++;
        if (onehot !== KEY_ENTER || pulseCount - p0 != 1) begin
            miscompares++;
            $display("[TB] FAIL bounce_settle: onehot=%h pulses=%0d expected %h/1", onehot, pulseCount - p0, KEY_ENTER);
        end
        keys = KEY_NONE;
        n = 0;
        while (onehot !== KEY_NONE && n < LIMIT) begin @(negedge clk); n++; end
        waitCycles(3 * FRAME);
    endtask

    task automatic test_multi();
        int n;
        int p0;
        p0 = pulseCount;
        keys = KEY_CLEAR | KEY_6;
        n = 0;
        while (multi_key !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
        waitCycles(FRAME);
        vectors++;
        if (multi_key !== 1'b1 || onehot !== KEY_NONE || pulseCount != p0) begin
            miscompares++;
            $display("[TB] FAIL chord_reject: multi=%b onehot=%h pulses=%0d expected 1/0000/0",
                     multi_key, onehot, pulseCount - p0);
        end
        expQ.push_back(KEY_CLEAR);
        keys = KEY_CLEAR;
        n = 0;
        while (onehot !== KEY_CLEAR && n < LIMIT) begin @(negedge clk); n++; end
        waitCycles(FRAME);
        vectors++;
        if (multi_key !== 1'b0 || onehot !== KEY_CLEAR || pulseCount - p0 != 1) begin
            miscompares++;
            $display("[TB] FAIL chord_drop: multi=%b onehot=%h pulses=%0d expected 0/%h/1",
                     multi_key, onehot, pulseCount - p0, KEY_CLEAR);
        end
        keys = KEY_NONE;
        n = 0;
        while (onehot !== KEY_NONE && n < LIMIT) begin @(negedge clk); n++; end
        waitCycles(3 * FRAME);
    endtask

    task automatic test_reset_mid();
        int n;
        int p0;
        expQ.push_back(KEY_7);
        keys = KEY_7;
        n = 0;
        while (onehot !== KEY_7 && n < LIMIT) begin @(negedge clk); n++; end
        waitCycles(FRAME + 5);
        p0 = pulseCount;
        RSTn = 1'b1;
        @(negedge clk);
        RSTn = 1'b0;
        vectors++;
        if (onehot !== KEY_NONE || row_n !== 4'b1110) begin
            miscompares++;
            $display("[TB] FAIL midframe_reset: onehot=%h row_n=%b expected 0000/1110", onehot, row_n);
        end
        expQ.push_back(KEY_7);
        n = 0;
        while (onehot !== KEY_7 && n < LIMIT) begin @(negedge clk); n++; end
        waitCycles(2 * FRAME);
        vectors++;
        if (onehot !== KEY_7 || pulseCount - p0 != 1) begin
            miscompares++;
            $display("[TB] FAIL reset_repress: onehot=%h pulses=%0d expected %h/1", onehot, pulseCount - p0, KEY_7);
        end
        keys = KEY_NONE;
        n = 0;
        while (onehot !== KEY_NONE && n < LIMIT) begin @(negedge clk); n++; end
        waitCycles(3 * FRAME);
    endtask

    task automatic test_back_to_back();
        int n;
        int p0;
        p0 = pulseCount;
        expQ.push_back(KEY_5);
        keys = KEY_5;
        n = 0;
        while (onehot !== KEY_5 && n < LIMIT) begin @(negedge clk); n++; end
        vectors++;
        if (onehot !== KEY_5) begin
            miscompares++;
            $display("[TB] FAIL slide_first: onehot=%h expected %h", onehot, KEY_5);
        end
        waitCycles(FRAME);
        expQ.push_back(KEY_4);
        keys = KEY_4;
        n = 0;
        while (onehot !== KEY_4 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        waitCycles(2 * FRAME);
        vectors++;
        if (onehot !== KEY_4 || pulseCount - p0 != 2) begin
            miscompares++;
            $display("[TB] FAIL slide_second: onehot=%h pulses=%0d expected %h/2", onehot, pulseCount - p0, KEY_4);
        end
        keys = KEY_NONE;
        n = 0;
        while (onehot !== KEY_NONE && n < LIMIT) begin @(negedge clk); n++; end
        waitCycles(3 * FRAME);
    endtask

    initial begin
        RSTn = 1'b1;
        keys = KEY_NONE;
        test_reset();
        test_hold();
        test_bounce();
        test_multi();
        test_reset_mid();
        test_back_to_back();
        vectors++;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL missing_pulses: %0d queued key codes never pulsed, expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
